data_packer: RTL
================

// Module: data_packer
// PURPOSE
// - Stage directly downstream of the vector-vector ALU; feeds the trace buffer.
// - Per chain, keeps the first 2^k elements of each valid vector, or drops the vector.
// - Packs kept elements densely into N-element lines. Emits a line when it is full, or at eof.
// - Latency is one cycle and there is no back-pressure: at most one line is emitted per cycle.
// PARAMETERS
// - N                  8   elements per vector and per output line (power of 2)
// - DATA_WIDTH         32  bits per element
// - MAX_CHAINS         4   number of firmware chains
// - PERSONAL_CONFIG_ID 0   configId value that addresses this block
// - INITIAL_COMMIT     '{MAX_CHAINS{1}}  per-chain keep(1)/drop(0), 8b each
// - INITIAL_SIZE_LOG2  '{MAX_CHAINS{0}}  per-chain k; kept elements = 2^k, k<=log2(N), 8b each
// PORTS
// - clk          in   1                   clock, rising edge
// - reset_n      in   1                   async active-low reset
// - tracing      in   1                   stage enable
// - valid_in     in   1                   input vector valid
// - eof_in       in   1                   last vector of frame
// - bof_in       in   1                   first vector of frame (passed into bof_out only)
// - chainId_in   in   $clog2(MAX_CHAINS)  selects the firmware entry
// - configId     in   8                   config target id
// - configData   in   8                   config byte
// - vector_in    in   DATA_WIDTH x [N]    input elements; element 0 is kept first
// - vector_out   out  DATA_WIDTH x [N]    packed line; unused slots are 0
// - elements_out out  $clog2(N)+1         count of valid elements in vector_out (1..N)
// - valid_out    out  1                   line valid, single-cycle pulse
// - eof_out      out  1                   line was closed by an eof
// - bof_out      out  1                   line contains a bof vector
// BEHAVIOUR
// Reset and configuration
// - Reset (async): outputs 0, fill=0, buffer=0, pending=0; config tables reload INITIAL_*.
// - A reset mid-line discards the partial line.
// - Config: each cycle with configId==PERSONAL_CONFIG_ID writes configData to slot cfg_ptr, then cfg_ptr++.
// - Slot order: COMMIT[0..MAX_CHAINS-1], then SIZE_LOG2[0..MAX_CHAINS-1].
// - cfg_ptr wraps to 0 after 2*MAX_CHAINS writes and resets to 0. Writes occur regardless of tracing.
// - SIZE_LOG2 > log2(N) is clamped to log2(N).
// Input acceptance
// - An input is accepted when tracing & valid_in & COMMIT[chainId_in]!=0.
// - Inputs with COMMIT==0, or arriving while tracing=0, are ignored.
// - Accepted input: s = 2^SIZE_LOG2[chainId_in].
// Line state
// - Buffer holds fill elements (0..N-1) and sticky bof/eof flags.
// - pending=1 means the buffer holds a closed line that must go out next.
// Per-cycle priority (tracing=1); the next state is registered, so latency is 1
// 1. pending: emit buffer. An accepted input starts a fresh buffer (fill=s).
//    Clear pending unless the fresh line is full (s==N) or has eof.
// 2. Accepted input and fill+s>N: emit buffer unchanged, zero-padded (elements_out=fill).
//    The input starts a fresh buffer (fill=s). Set pending if s==N or eof_in.
// 3. Accepted input and fill+s<=N: place vector_in[0..s-1] at slots fill..fill+s-1.
//    If fill+s==N or eof_in: emit the merged line directly, with buffer->0 and fill->0.
//    Otherwise fill+=s.
// 4. No accepted input: no emission.
// - eof on the first vector with fill==0 emits a line of s elements.
// Output rules
// - Cycles with no emission: valid_out=0. vector_out, elements_out, eof_out and bof_out hold their last value.
// - eof_out and bof_out are the OR of the flags of every vector placed in the emitted line.
// - tracing=0: no emission and state is frozen; pending drains after tracing returns to 1.
// TESTING
// - N=8, k=0 on chain 0, 8 inputs 1..8, then eof on the 8th
//   -> one line [1..8], elements_out=8, eof_out=1.
// - k=2 (4 elements), inputs A, B back-to-back
//   -> one line {A[0..3],B[0..3]} one cycle after B.
// - k=2 with fill=6 (chain 1 at k=1 placed 2+2+2), then a k=2 input C
//   -> emits 6-element line with slots 6,7=0; next line starts with C[0..3].
// - Overflow plus eof (fill=6, C with eof_in=1)
//   -> cycle t+1 emits the 6-element line, t+2 emits {C[0..3],0..} with eof_out=1.
//   -> An input D on t+1 starts the line after C's, with no loss.
// - Config: write bytes 0,1,1,1,3,3,3,3 with configId=PERSONAL_CONFIG_ID
//   -> chain 0 inputs produce no output; chain 1 packs 8 elements per line.
// - Assert reset_n=0 with fill=4 and pending=1
//   -> valid_out=0 immediately; no stale line after release; config reverts to INITIAL_*.

Source files
------------

// File: rtl/data_packer_if.sv
// Stream bundle between the vector ALU, the packer and the trace buffer.
// slave is the packer side; master is whoever drives vectors and consumes lines.
interface data_packer_if #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_CHAINS = 4
);
  localparam int CW  = $clog2(N) + 1;
  localparam int CHW = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1;

  logic                           valid_in;
  logic                           eof_in;
  logic                           bof_in;
  logic [CHW-1:0]                 chainId_in;
  logic [N-1:0][DATA_WIDTH-1:0]   vector_in;

  logic [N-1:0][DATA_WIDTH-1:0]   vector_out;
  logic [CW-1:0]                  elements_out;
  logic                           valid_out;
  logic                           eof_out;
  logic                           bof_out;

  modport slave (
    input  valid_in, eof_in, bof_in, chainId_in, vector_in,
    output vector_out, elements_out, valid_out, eof_out, bof_out
  );

  modport master (
    output valid_in, eof_in, bof_in, chainId_in, vector_in,
    input  vector_out, elements_out, valid_out, eof_out, bof_out
  );
endinterface

// File: rtl/data_packer.sv
// Keeps the first 2^k elements of each committed vector and packs them densely
// into N-element lines; one registered line per cycle at most, no back-pressure.
module data_packer #(
  parameter int N                  = 8,
  parameter int DATA_WIDTH         = 32,
  parameter int MAX_CHAINS         = 4,
  parameter int PERSONAL_CONFIG_ID = 0,
  parameter logic [7:0] INITIAL_COMMIT    [MAX_CHAINS] = '{default: 8'd1},
  parameter logic [7:0] INITIAL_SIZE_LOG2 [MAX_CHAINS] = '{default: 8'd0}
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tracing,
  input  logic [7:0]        configId,
  input  logic [7:0]        configData,
  data_packer_if.slave      bus
);
  localparam int LW  = $clog2(N);
  localparam int CW  = LW + 1;
  localparam int PW  = $clog2(2 * MAX_CHAINS);
  localparam logic [7:0] LW8 = 8'(LW);

  typedef logic [N-1:0][DATA_WIDTH-1:0] line_t;

  // ---------------- configuration tables ----------------
  logic [PW-1:0]                 cfg_ptr_reg;
  logic                          cfg_we;
  logic [7:0]                    cfg_size;
  logic [MAX_CHAINS-1:0]         committed;
  logic [MAX_CHAINS-1:0][7:0]    size_tab;

  assign cfg_we   = (configId == 8'(PERSONAL_CONFIG_ID));
  assign cfg_size = (configData > LW8) ? LW8 : configData;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cfg_ptr_reg <= '0;
    else if (cfg_we)
      cfg_ptr_reg <= (cfg_ptr_reg == PW'(2 * MAX_CHAINS - 1)) ? '0 : cfg_ptr_reg + 1'b1;
  end

  genvar gi;
  generate
    for (gi = 0; gi < MAX_CHAINS; gi++) begin : g_chain
      logic [7:0] commit_reg;
      logic [7:0] size_reg;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          commit_reg <= INITIAL_COMMIT[gi];
          size_reg   <= (INITIAL_SIZE_LOG2[gi] > LW8) ? LW8 : INITIAL_SIZE_LOG2[gi];
        end else if (cfg_we) begin
          if (cfg_ptr_reg == PW'(gi))
            commit_reg <= configData;
          if (cfg_ptr_reg == PW'(MAX_CHAINS + gi))
            size_reg <= cfg_size;
        end
      end

      assign committed[gi] = (commit_reg != 8'd0);
      assign size_tab[gi]  = size_reg;
    end
  endgenerate

  // ---------------- line state ----------------
  line_t           buf_reg, buf_next;
  logic [CW-1:0]   fill_reg, fill_next;
  logic            bof_reg, bof_next;
  logic            eof_reg, eof_next;
  logic            pending_reg, pending_next;

  line_t           vec_out_reg;
  logic [CW-1:0]   elem_out_reg;
  logic            valid_out_reg, eof_out_reg, bof_out_reg;

  logic            accept;
  logic [CW-1:0]   s;
  logic [CW:0]     sum;
  logic            overflow;
  logic            fresh_closes;
  line_t           fresh;
  line_t           merged;

  logic            emit;
  line_t           emit_vec;
  logic [CW-1:0]   emit_n;
  logic            emit_eof, emit_bof;

  assign accept       = tracing & bus.valid_in & committed[bus.chainId_in];
  assign s            = CW'(1) << size_tab[bus.chainId_in];
  assign sum          = {1'b0, fill_reg} + {1'b0, s};
  assign overflow     = (sum > (CW + 1)'(N));
  assign fresh_closes = (s == CW'(N)) || bus.eof_in;

  // fresh: input alone at slot 0; merged: input appended after the current fill
  generate
    for (gi = 0; gi < N; gi++) begin : g_slot
      logic [LW-1:0] rel;
      logic          in_merge;

      assign rel      = LW'(gi) - fill_reg[LW-1:0];
      assign in_merge = (CW'(gi) >= fill_reg) && ((CW + 1)'(gi) < sum);
      assign merged[gi] = in_merge ? bus.vector_in[rel] : buf_reg[gi];
      assign fresh[gi]  = (CW'(gi) < s) ? bus.vector_in[gi] : '0;
    end
  endgenerate

  // next-state / emission decision
  always_comb begin
    buf_next     = buf_reg;
    fill_next    = fill_reg;
    bof_next     = bof_reg;
    eof_next     = eof_reg;
    pending_next = pending_reg;
    emit         = 1'b0;
    emit_vec     = buf_reg;
    emit_n       = fill_reg;
    emit_eof     = eof_reg;
    emit_bof     = bof_reg;

    if (tracing) begin
      if (pending_reg || (accept && overflow)) begin
        emit = 1'b1;
        if (accept) begin
          buf_next     = fresh;
          fill_next    = s;
          bof_next     = bus.bof_in;
          eof_next     = bus.eof_in;
          pending_next = fresh_closes;
        end else begin
          buf_next     = '0;
          fill_next    = '0;
          bof_next     = 1'b0;
          eof_next     = 1'b0;
          pending_next = 1'b0;
        end
      end else if (accept) begin
        if ((sum == (CW + 1)'(N)) || bus.eof_in) begin
          emit      = 1'b1;
          emit_vec  = merged;
          emit_n    = sum[CW-1:0];
          emit_eof  = eof_reg | bus.eof_in;
          emit_bof  = bof_reg | bus.bof_in;
          buf_next  = '0;
          fill_next = '0;
          bof_next  = 1'b0;
          eof_next  = 1'b0;
        end else begin
          buf_next  = merged;
          fill_next = sum[CW-1:0];
          bof_next  = bof_reg | bus.bof_in;
          eof_next  = eof_reg | bus.eof_in;
        end
      end
    end
  end

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_reg     <= '0;
      fill_reg    <= '0;
      bof_reg     <= 1'b0;
      eof_reg     <= 1'b0;
      pending_reg <= 1'b0;
    end else begin
      buf_reg     <= buf_next;
      fill_reg    <= fill_next;
      bof_reg     <= bof_next;
      eof_reg     <= eof_next;
      pending_reg <= pending_next;
    end
  end

  // output register: line fields hold between emissions
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vec_out_reg   <= '0;
      elem_out_reg  <= '0;
      valid_out_reg <= 1'b0;
      eof_out_reg   <= 1'b0;
      bof_out_reg   <= 1'b0;
    end else begin
      valid_out_reg <= emit;
      if (emit) begin
        vec_out_reg  <= emit_vec;
        elem_out_reg <= emit_n;
        eof_out_reg  <= emit_eof;
        bof_out_reg  <= emit_bof;
      end
    end
  end

  always_comb begin
    bus.vector_out   = vec_out_reg;
    bus.elements_out = elem_out_reg;
    bus.valid_out    = valid_out_reg;
    bus.eof_out      = eof_out_reg;
    bus.bof_out      = bof_out_reg;
  end
endmodule
